// File: rtl/booth2_pkg.sv
// booth2_pkg: shared types and helpers for the radix-4 Booth multiplier.
//   state_t       - controller states (IDLE / CALC / DONE)
//   digit_t       - Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2)
//   booth2_iters  - number of Booth digits for a given operand width
//   booth2_digit  - recodes a multiplier triplet {y[2i+1], y[2i], y[2i-1]}
package booth2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } digit_t;

  function automatic int unsigned booth2_iters(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic digit_t booth2_digit(input logic [2:0] triplet);
    digit_t d;
    case (triplet)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth2_pp_sel.sv
// booth2_pp_sel: combinational partial-product selector.
// Recodes one multiplier triplet into a Booth digit, multiplies the extended
// multiplicand by it and shifts the result into accumulator position 2*idx.
//   triplet [2:0]        - {y[2i+1], y[2i], y[2i-1]}
//   xe      [WIDTH+1:0]  - multiplicand, already sign/zero extended
//   idx     [IW-1:0]     - digit index i
//   pp      [2*WIDTH+3:0]- signed partial product, two's complement
module booth2_pp_sel
  import booth2_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IW    = 4
) (
  input  logic [2:0]         triplet,
  input  logic [WIDTH+1:0]   xe,
  input  logic [IW-1:0]      idx,
  output logic [2*WIDTH+3:0] pp
);

  localparam int unsigned AW = 2 * WIDTH + 4;

  logic [AW-1:0] x1;
  logic [AW-1:0] x2;
  logic [AW-1:0] mag;
  digit_t        dig;

  always_comb begin
    x1  = {{(WIDTH + 2){xe[WIDTH+1]}}, xe};
    x2  = x1 << 1;
    dig = booth2_digit(triplet);
    case (dig)
      POS1:    mag = x1;
      POS2:    mag = x2;
      NEG1:    mag = -x1;
      NEG2:    mag = -x2;
      default: mag = '0;
    endcase
    pp = mag << {idx, 1'b0};
  end

endmodule

// File: rtl/booth2_mul.sv
// booth2_mul: sequential radix-4 Booth multiplier, one digit per cycle.
//   clk, rst       - clock, synchronous active-high reset
//   start          - request, accepted in IDLE or DONE
//   is_signed      - 1: two's-complement operands, 0: unsigned
//   x, y [WIDTH]   - multiplicand / multiplier, sampled with start
//   z [2*WIDTH]    - product, held until next completion or reset
//   busy           - operation in progress
//   done           - one-cycle pulse when z has just been updated
// Optional feature macro: BOOTH2_EARLY_TERM_EN (stop once all remaining
// Booth digits are zero; result unchanged, latency data-dependent).
module booth2_mul
  import booth2_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] z,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N  = booth2_iters(WIDTH);
  localparam int unsigned IW = $clog2(N + 1);
  localparam int unsigned AW = 2 * WIDTH + 4;
  localparam int unsigned YW = WIDTH + 3;
  localparam logic [IW-1:0] LAST = IW'(N);

  state_t          state;
  logic [WIDTH+1:0] xe;
  // Multiplier with the y[-1]=0 overlap bit appended; shifted right by two
  // each digit so the current triplet is always yq[2:0].
  logic [YW-1:0]   yq;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   pp;
  logic [IW-1:0]   cnt;
  logic            rest_zero;
  logic            sx;
  logic            sy;

  booth2_pp_sel #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_pp_sel (
    .triplet (yq[2:0]),
    .xe      (xe),
    .idx     (cnt),
    .pp      (pp)
  );

  always_comb begin
    sx = is_signed & x[WIDTH-1];
    sy = is_signed & y[WIDTH-1];
`ifdef BOOTH2_EARLY_TERM_EN
    // Arithmetic shifting keeps the fill equal to the extension bit, so an
    // all-equal yq means every remaining triplet recodes to ZERO.
    rest_zero = (yq == '0) || (yq == '1);
`else
    rest_zero = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      z     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      xe    <= '0;
      yq    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xe    <= {{2{sx}}, x};
            yq    <= {{2{sy}}, y, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            z     <= acc[2*WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (rest_zero) begin
            cnt <= LAST;
          end else begin
            acc <= acc + pp;
            yq  <= {{2{yq[YW-1]}}, yq[YW-1:2]};
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth2_mul.sv
// tb_booth2_mul: directed self-checking bench for booth2_mul (WIDTH=16 and 8).
module tb_booth2_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        start16, sgn16;
  logic [15:0] x16, y16;
  logic [31:0] z16;
  logic        busy16, done16;
  logic        start8, sgn8;
  logic [7:0]  x8, y8;
  logic [15:0] z8;
  logic        busy8, done8;

  int checks   = 0;
  int failures = 0;
  logic overlap_seen = 1'b0;

  always #5 clk = ~clk;

  booth2_mul #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .is_signed(sgn16),
    .x(x16), .y(y16), .z(z16), .busy(busy16), .done(done16)
  );

  booth2_mul #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .x(x8), .y(y8), .z(z8), .busy(busy8), .done(done8)
  );

  always @(negedge clk) begin
    if (!rst && ((busy16 && done16) || (busy8 && done8))) overlap_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one WIDTH=16 operation and return cycles from accept edge to done.
  task automatic op16(input logic s, input logic [15:0] a, input logic [15:0] b, output int lat);
    @(negedge clk);
    start16 = 1'b1; sgn16 = s; x16 = a; y16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; x16 = 16'($urandom); y16 = 16'($urandom); sgn16 = ~s;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
  endtask

  task automatic op8(input logic s, input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; x8 = a; y8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1;
    start16 = 1'b0; sgn16 = 1'b0; x16 = '0; y16 = '0;
    start8  = 1'b0; sgn8  = 1'b0; x8  = '0; y8  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_z",    64'(z16),    64'h0);
    check("reset_busy", 64'(busy16), 64'h0);
    check("reset_done", 64'(done16), 64'h0);
    @(negedge clk); rst = 1'b0;

    op16(1'b1, 16'h0006, 16'h0005, lat);
    check("s6x5_lat", 64'(lat), 64'd10);
    check("s6x5_z",   64'(z16), 64'h0000001E);
    op16(1'b1, 16'hFFFA, 16'h0005, lat);
    check("sneg6x5_z", 64'(z16), 64'hFFFFFFE2);
    op16(1'b1, 16'h8001, 16'h6578, lat);
    check("s8001_z", 64'(z16), 64'hCD446578);
    op16(1'b1, 16'h0589, 16'hC643, lat);
    check("s0589_z", 64'(z16), 64'hFEC068DB);
    op16(1'b0, 16'hFFFF, 16'hFFFF, lat);
    check("u_ffff_z",   64'(z16), 64'hFFFE0001);
    check("u_ffff_lat", 64'(lat), 64'd10);
    op16(1'b1, 16'hFFFF, 16'hFFFF, lat);
    check("s_ffff_z", 64'(z16), 64'h00000001);

    op8(1'b1, 8'h80, 8'h80, lat);
    check("w8_s80_z",   64'(z8),  64'h4000);
    check("w8_s80_lat", 64'(lat), 64'd6);
    op8(1'b0, 8'hFF, 8'h02, lat);
    check("w8_uff_z", 64'(z8), 64'h01FE);

    // start pulsed mid-CALC must be ignored
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b1; x16 = 16'd6; y16 = 16'd7;
    @(posedge clk); #1; start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) begin start16 = 1'b1; x16 = 16'd100; y16 = 16'd100; end
      if (i == 5) start16 = 1'b0;
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
    check("ign_start_lat", 64'(lat), 64'd10);
    check("ign_start_z",   64'(z16), 64'd42);

    // back-to-back: start held high through the done cycle
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b1; x16 = 16'd3; y16 = 16'd4;
    @(posedge clk); #1;
    x16 = 16'hFFFF; y16 = 16'd2;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
    check("b2b_first_lat", 64'(lat), 64'd10);
    check("b2b_first_z",   64'(z16), 64'd12);
    @(posedge clk); #1;
    check("b2b_accept_busy", 64'(busy16), 64'h1);
    start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done16) begin lat = i; break; end
    end
    check("b2b_second_lat", 64'(lat), 64'd10);
    check("b2b_second_z",   64'(z16), 64'hFFFFFFFE);

    // reset mid-CALC, with a simultaneous start that must not be accepted
    @(negedge clk);
    start16 = 1'b1; sgn16 = 1'b0; x16 = 16'd5; y16 = 16'd5;
    @(posedge clk); #1; start16 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy16), 64'h0);
    check("rst_z",    64'(z16),    64'h0);
    check("rst_done", 64'(done16), 64'h0);
    @(negedge clk); rst = 1'b0; start16 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen = 1'b1;
    end
    check("rst_no_activity", 64'(seen), 64'h0);

    op16(1'b0, 16'h1234, 16'h0000, lat);
    check("y0_z", 64'(z16), 64'h0);
`ifdef BOOTH2_EARLY_TERM_EN
    check("y0_lat", 64'(lat), 64'd2);
`else
    check("y0_lat", 64'(lat), 64'd10);
`endif
    op16(1'b1, 16'h1234, 16'h1234, lat);
    check("sq1234_z", 64'(z16), 64'h014B5A90);
`ifdef BOOTH2_EARLY_TERM_EN
    check("sq1234_lat", 64'(lat), 64'd9);
`else
    check("sq1234_lat", 64'(lat), 64'd10);
`endif

    check("busy_done_overlap", 64'(overlap_seen), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
